// File: rtl/filt_interp_linear_if.sv
// rtl/filt_interp_linear_if.sv - input/output stream handshake bundle for filt_interp_linear
interface filt_interp_linear_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] data_out;

    // master: the side that produces input samples and consumes outputs
    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out
    );

    // slave: the interpolator itself
    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out
    );
endinterface

// File: rtl/filt_interp_linear.sv
// rtl/filt_interp_linear.sv - linear-interpolating upsampler, 2**INTERP_POWER outputs per input
module filt_interp_linear #(
    parameter int DATA_WIDTH   = 16,
    parameter int INTERP_POWER = 3
) (
    input  logic               clk,
    input  logic               rst,
    filt_interp_linear_if.slave bus
);
    localparam int AW = DATA_WIDTH + INTERP_POWER + 1;
    localparam logic [INTERP_POWER-1:0] LAST = '1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                         state_q, state_d;
    logic signed [DATA_WIDTH-1:0]   prev_q, cur_q, din, prev_eff;
    logic signed [DATA_WIDTH:0]     diff_q;
    logic signed [AW-1:0]           acc_q;
    logic [INTERP_POWER-1:0]        phase_q;
    logic                           last_phase, xfer, accept, rdy;

    assign din        = bus.data_in;
    assign last_phase = (phase_q == LAST);
    assign xfer       = (state_q == RUN) && bus.out_ready;
    assign rdy        = !rst && ((state_q == IDLE) ||
                                 ((state_q == RUN) && last_phase && bus.out_ready));
    assign accept     = bus.in_valid && rdy;

    // A load coinciding with the final transfer must ramp from the sample just finished.
    assign prev_eff   = (xfer && last_phase) ? cur_q : prev_q;

    assign bus.in_ready  = rdy;
    assign bus.out_valid = (state_q == RUN);
    assign bus.data_out  = DATA_WIDTH'(acc_q >>> INTERP_POWER);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN:  if (xfer && last_phase) state_d = accept ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= '0;
            cur_q   <= '0;
            diff_q  <= '0;
            acc_q   <= '0;
            phase_q <= '0;
        end else begin
            if (xfer && last_phase) prev_q <= cur_q;
            if (accept) begin
                cur_q   <= din;
                diff_q  <= (DATA_WIDTH+1)'(din) - (DATA_WIDTH+1)'(prev_eff);
                acc_q   <= AW'(prev_eff) <<< INTERP_POWER;
                phase_q <= '0;
            end else if (xfer && !last_phase) begin
                acc_q   <= acc_q + AW'(diff_q);
                phase_q <= phase_q + INTERP_POWER'(1);
            end
        end
    end
endmodule

// File: tb/tb_filt_interp_linear.sv
// tb/tb_filt_interp_linear.sv - directed and backpressure bench for filt_interp_linear
module tb_filt_interp_linear;
    localparam int DW = 16;
    localparam int IP = 3;
    localparam int L  = 1 << IP;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    filt_interp_linear_if #(.DATA_WIDTH(DW)) ifc ();

    filt_interp_linear #(.DATA_WIDTH(DW), .INTERP_POWER(IP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sd();
        return int'($signed(ifc.data_out));
    endfunction

    function automatic int model(input int p, input int c, input int k);
        return (p * L + k * (c - p)) >>> IP;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        ifc.in_valid = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", int'(ifc.in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        ifc.in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", int'(ifc.in_ready), 1);
        chk("post_rst_out_valid", int'(ifc.out_valid), 0);
        chk("post_rst_data", sd(), 0);
    endtask

    task automatic feed_run(input string tag, input int val, input int exp_v [L]);
        int n;
        @(posedge clk); #1;
        ifc.in_valid  = 1'b1;
        ifc.data_in   = DW'(val);
        ifc.out_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ifc.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk({tag, "_accept_timeout"}, n, 0);
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        for (int k = 0; k < L; k++) begin
            @(negedge clk);
            chk($sformatf("%s_valid%0d", tag, k), int'(ifc.out_valid), 1);
            chk($sformatf("%s_data%0d", tag, k), sd(), exp_v[k]);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk({tag, "_idle"}, int'(ifc.out_valid), 0);
    endtask

    initial begin : stim
        int exp_v [L];
        int expq [$];
        int mprev, cval, sent, cyc, held, prior_acc, last_acc, dval;
        bit stalled;

        ifc.in_valid  = 1'b0;
        ifc.data_in   = '0;
        ifc.out_ready = 1'b0;

        do_reset();

        // basic ramp
        exp_v = '{0, 1, 2, 3, 4, 5, 6, 7};
        feed_run("ramp8", 8, exp_v);
        exp_v = '{8, 9, 10, 11, 12, 13, 14, 15};
        feed_run("ramp16", 16, exp_v);

        // negative values, floor rounding
        do_reset();
        exp_v = '{0, -1, -1, -1, -1, -1, -1, -1};
        feed_run("neg1", -1, exp_v);
        exp_v = '{-1, -2, -3, -4, -5, -6, -7, -8};
        feed_run("neg9", -9, exp_v);

        // extremes
        do_reset();
        exp_v = '{0, 4095, 8191, 12287, 16383, 20479, 24575, 28671};
        feed_run("max", 32767, exp_v);
        exp_v = '{32767, 24575, 16383, 8191, -1, -8193, -16385, -24577};
        feed_run("min", -32768, exp_v);

        // reset mid-run
        do_reset();
        @(posedge clk); #1;
        ifc.in_valid  = 1'b1;
        ifc.data_in   = DW'(8);
        ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", int'(ifc.out_valid), 0);
        exp_v = '{0, 1, 2, 3, 4, 5, 6, 7};
        feed_run("midrst_ramp", 8, exp_v);

        // random backpressure against the closed-form model
        do_reset();
        mprev = 0; sent = 0; cyc = 0; stalled = 1'b0; held = 0;
        cval = int'($urandom_range(0, 65535)) - 32768;
        while (cyc < 5000 && (sent < 100 || expq.size() > 0 || ifc.out_valid)) begin
            @(posedge clk); #1;
            ifc.out_ready = 1'($urandom_range(0, 1));
            ifc.in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
            ifc.data_in   = DW'(cval);
            @(negedge clk);
            if (stalled && ifc.out_valid) chk("bp_stable", sd(), held);
            if (ifc.out_valid && ifc.out_ready) begin
                if (expq.size() == 0) chk("bp_extra_output", 1, 0);
                else chk($sformatf("bp_data_in%0d", sent), sd(), expq.pop_front());
            end
            if (ifc.in_valid && ifc.in_ready) begin
                for (int k = 0; k < L; k++) expq.push_back(model(mprev, cval, k));
                mprev = cval;
                sent++;
                cval = int'($urandom_range(0, 65535)) - 32768;
            end
            stalled = ifc.out_valid && !ifc.out_ready;
            held = sd();
            cyc++;
        end
        chk("bp_inputs_sent", sent, 100);
        chk("bp_outputs_left", expq.size(), 0);

        // back-to-back streaming
        do_reset();
        dval = 100;
        @(posedge clk); #1;
        ifc.in_valid  = 1'b1;
        ifc.out_ready = 1'b1;
        ifc.data_in   = DW'(dval);
        prior_acc = 0;
        last_acc  = dval;
        @(posedge clk); #1;
        dval = dval + 1237;
        ifc.data_in = DW'(dval);
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            chk($sformatf("b2b_valid%0d", c), int'(ifc.out_valid), 1);
            chk($sformatf("b2b_ready%0d", c), int'(ifc.in_ready), int'((c % L) == L - 1));
            if ((c % L) == 0) chk($sformatf("b2b_phase0_%0d", c), sd(), prior_acc);
            if (ifc.in_ready) begin
                prior_acc = last_acc;
                last_acc  = dval;
            end
            @(posedge clk); #1;
            if (last_acc == dval) begin
                dval = dval - 3001;
                ifc.data_in = DW'(dval);
            end
        end
        ifc.in_valid = 1'b0;
        repeat (L + 2) @(posedge clk);
        @(negedge clk);
        chk("b2b_drained", int'(ifc.out_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/filt_interp_linear.md
# filt_interp_linear

Parameterized linear-interpolating upsampler. Each input sample is expanded into 2**INTERP_POWER output samples that ramp linearly from the previous input sample toward the current one. It is the rate-increasing counterpart of the moving-average decimation path: the TX/DAC-side chain uses it to raise sample rate before the baseband-to-RF stages. Both sides use valid/ready streaming handshakes. The block is fully synchronous and has no overflow, because every output lies between two legal input values.

## Interface
- DATA_WIDTH, 16, width of input and output samples (signed two's complement)
- INTERP_POWER, 3, log2 of the interpolation factor; L = 2**INTERP_POWER, valid range 1..8
- clk  input  1  single clock; all logic on the rising edge
- rst  input  1  reset, synchronous and active-high
- in_valid  input  1  data_in holds a sample
- in_ready  output  1  block accepts a sample this cycle
- data_in  input  DATA_WIDTH  signed input sample
- out_valid  output  1  data_out holds an interpolated sample
- out_ready  input  1  downstream accepts data_out this cycle
- data_out  output  DATA_WIDTH  signed interpolated sample

## Operation
- Registers:
  - prev (DATA_WIDTH): last fully consumed input; 0 after reset.
  - diff (DATA_WIDTH+1, signed): current input minus prev.
  - acc (DATA_WIDTH+INTERP_POWER+1, signed).
  - phase (INTERP_POWER bits).
  - cur (DATA_WIDTH).
  - state.
- States:
  - IDLE: out_valid=0, in_ready=1.
  - RUN: emits L outputs.
- Input accept occurs when in_valid && in_ready. It loads:
  - cur <= data_in
  - diff <= data_in - prev, sign-extended to DATA_WIDTH+1
  - acc <= prev << INTERP_POWER, sign-extended
  - phase <= 0
  - state <= RUN
- data_out = acc >>> INTERP_POWER, the arithmetic shift with floor rounding, truncated to DATA_WIDTH. Truncation is lossless by construction.
- Output k of a run (k = 0..L-1) = floor((prev*L + k*(cur-prev)) / L).
- Output transfer (out_valid && out_ready) in RUN:
  - If phase < L-1: acc <= acc + diff, phase <= phase+1.
  - If phase == L-1: prev <= cur. If an input is accepted the same cycle, the new load uses the updated prev (i.e. cur) and the block stays in RUN. Otherwise go to IDLE.
- in_ready = (state==IDLE) || (state==RUN && phase==L-1 && out_ready). in_ready is combinational from out_ready; it must never depend on in_valid.
- out_valid = (state==RUN).
- While out_valid=1 and out_ready=0, data_out and out_valid hold stable and no phase advances.
- Reset:
  - Clears prev, cur, diff, acc and phase to 0, sets state to IDLE, and forces in_ready=0 while rst=1.
  - Any run in progress is discarded.
  - Reset has priority over any simultaneous handshake.

## Timing
- Every output register has a reset value of 0 and is driven from registers, except in_ready, which is combinational as defined above.
- Latency: an input accepted on edge t produces its phase-0 output (value = prev) with out_valid=1 after edge t.
- The signal path therefore carries a one-input-sample delay. The ramp toward sample n completes only when sample n+1 arrives.
- Steady state with in_valid=1 and out_ready=1 continuously:
  - out_valid=1 on every cycle, with no bubbles.
  - in_ready pulses exactly once every L cycles, coincident with phase L-1.
- Without a following input, the block returns to IDLE on the edge that consumes phase L-1, and out_valid drops on the next cycle.
- First cycle after rst deasserts: IDLE, in_ready=1, out_valid=0.

## Test plan
- **Basic ramp.** Reset, then feed 8 with out_ready=1. Required: data_out = 0,1,2,3,4,5,6,7, then out_valid=0. Then feed 16. Required: 8,9,...,15.
- **Negative values and floor rounding.** After reset, feed -1. Required: 0,-1,-1,-1,-1,-1,-1,-1. Then feed -9. Required: -1,-2,...,-8.
- **Extremes (DATA_WIDTH=16, L=8).** Feed 0x7FFF and let it complete, then feed 0x8000. Required: second run = 32767, 24575, 16383, 8191, -1, -8193, -16385, -24577. No wrap.
- **Backpressure.** Use a pseudo-random out_ready (about 50%) over 100 random inputs. Required:
  - data_out is stable while stalled.
  - Exactly L outputs per input.
  - Values match the reference model.
- **Back-to-back streaming.** Hold in_valid=1 with a new value every accept and out_ready=1 for 64 cycles. Required:
  - out_valid stays continuously high.
  - in_ready is high exactly on phase L-1 cycles.
  - Each phase-0 output equals the preceding input.
- **Reset mid-run.** After feed 8 and three output transfers, pulse rst for one cycle. Required:
  - out_valid=0 on the next cycle.
  - A subsequent feed of 8 produces 0,1,...,7, which shows prev cleared to 0.
